// File: rtl/traffic_pkg.sv
// Shared types and default timing for the multi-way traffic intersection controller.
package traffic_pkg;

    typedef enum logic [1:0] {
        ALL_RED = 2'd0,
        GREEN   = 2'd1,
        YELLOW  = 2'd2,
        FLASH   = 2'd3
    } state_e;

    localparam int unsigned DEF_N_WAYS    = 2;
    localparam int unsigned DEF_GRN_CYC   = 8;
    localparam int unsigned DEF_YLW_CYC   = 3;
    localparam int unsigned DEF_AR_CYC    = 2;
    localparam int unsigned DEF_WALK_CYC  = 4;
    localparam int unsigned DEF_FLASH_CYC = 5;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that times each lamp phase; saturates at zero.
module phase_timer #(
    parameter int unsigned CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic [CW-1:0] value,
    output logic          done
);

    logic [CW-1:0] value_q, value_d;
    logic          done_q, done_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_val;
        end else if (value_q != '0) begin
            value_d = value_q - CW'(1);
        end
        done_d = (value_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= '0;
            done_q  <= 1'b1;
        end else begin
            value_q <= value_d;
            done_q  <= done_d;
        end
    end

    assign value = value_q;
    assign done  = done_q;

endmodule

// File: rtl/multi_way_intersection.sv
// Round-robin traffic light controller with pedestrian walk service and flashing-yellow mode.
module multi_way_intersection
    import traffic_pkg::*;
#(
    parameter int unsigned N_WAYS    = DEF_N_WAYS,
    parameter int unsigned GRN_CYC   = DEF_GRN_CYC,
    parameter int unsigned YLW_CYC   = DEF_YLW_CYC,
    parameter int unsigned AR_CYC    = DEF_AR_CYC,
    parameter int unsigned WALK_CYC  = DEF_WALK_CYC,
    parameter int unsigned FLASH_CYC = DEF_FLASH_CYC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_WAYS-1:0] ped_req,
    input  logic              flash_mode,
    output logic [N_WAYS-1:0] red,
    output logic [N_WAYS-1:0] ylw,
    output logic [N_WAYS-1:0] grn,
    output logic [N_WAYS-1:0] walk
);

    localparam int unsigned MAX_CYC = max2(max2(GRN_CYC, YLW_CYC), max2(AR_CYC, FLASH_CYC));
    localparam int unsigned CW      = $clog2(MAX_CYC + 1);
    localparam int unsigned WW      = $clog2(N_WAYS);

    localparam logic [CW-1:0] GRN_LD   = CW'(GRN_CYC - 1);
    localparam logic [CW-1:0] YLW_LD   = CW'(YLW_CYC - 1);
    localparam logic [CW-1:0] AR_LD    = CW'(AR_CYC - 1);
    localparam logic [CW-1:0] FLASH_LD = CW'(FLASH_CYC - 1);
    localparam logic [CW-1:0] AR_FIRST = CW'((AR_CYC > 1) ? AR_CYC - 2 : 0);
    localparam logic [CW-1:0] WALK_MIN = CW'(GRN_CYC - WALK_CYC);
    localparam logic [WW-1:0] LAST_WAY = WW'(N_WAYS - 1);

    if (N_WAYS < 2 || N_WAYS > 8 || GRN_CYC < 1 || YLW_CYC < 1 || AR_CYC < 1 ||
        WALK_CYC < 1 || WALK_CYC > GRN_CYC || FLASH_CYC < 1) begin : g_param_err
        $error("multi_way_intersection: illegal parameter value");
    end

    state_e            state_q, state_d;
    logic [WW-1:0]     cur_way_q, cur_way_d;
    logic [N_WAYS-1:0] ped_pend_q, ped_pend_d;
    logic              serviced_q, serviced_d;
    logic              flash_on_q, flash_on_d;
    logic              fresh_q, fresh_d;

    logic [N_WAYS-1:0] red_q, red_d, ylw_q, ylw_d, grn_q, grn_d, walk_q, walk_d;

    logic              t_load;
    logic [CW-1:0]     t_val;
    logic [CW-1:0]     t_value;
    logic              t_done;

    phase_timer #(.CW(CW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (t_load),
        .load_val (t_val),
        .value    (t_value),
        .done     (t_done)
    );

    // Next-state, way pointer and pending-request bookkeeping.
    always_comb begin
        state_d    = state_q;
        cur_way_d  = cur_way_q;
        ped_pend_d = ped_pend_q | ped_req;
        serviced_d = serviced_q;
        flash_on_d = flash_on_q;
        fresh_d    = 1'b0;
        t_load     = 1'b0;
        t_val      = '0;

        case (state_q)
            ALL_RED: begin
                // Timer holds zero out of reset, so the first clearance is stretched to full length.
                if (fresh_q && (AR_CYC > 1)) begin
                    t_load = 1'b1;
                    t_val  = AR_FIRST;
                end else if (t_done) begin
                    t_load = 1'b1;
                    if (flash_mode) begin
                        state_d    = FLASH;
                        flash_on_d = 1'b1;
                        t_val      = FLASH_LD;
                    end else begin
                        state_d               = GREEN;
                        serviced_d            = ped_pend_d[cur_way_q];
                        ped_pend_d[cur_way_q] = 1'b0;
                        t_val                 = GRN_LD;
                    end
                end
            end
            GREEN: begin
                if (t_done) begin
                    state_d = YELLOW;
                    t_load  = 1'b1;
                    t_val   = YLW_LD;
                end
            end
            YELLOW: begin
                if (t_done) begin
                    state_d   = ALL_RED;
                    t_load    = 1'b1;
                    t_val     = AR_LD;
                    cur_way_d = (cur_way_q == LAST_WAY) ? '0 : cur_way_q + WW'(1);
                end
            end
            FLASH: begin
                if (t_done) begin
                    t_load = 1'b1;
                    t_val  = FLASH_LD;
                    if (flash_on_q) begin
                        flash_on_d = 1'b0;
                    end else if (!flash_mode) begin
                        state_d = ALL_RED;
                        t_val   = AR_LD;
                    end else begin
                        flash_on_d = 1'b1;
                    end
                end
            end
            default: state_d = ALL_RED;
        endcase
    end

    // Lamp decode from the upcoming state so the lamp flops track the state register.
    always_comb begin
        red_d  = '1;
        ylw_d  = '0;
        grn_d  = '0;
        walk_d = '0;
        case (state_d)
            GREEN: begin
                red_d[cur_way_d]  = 1'b0;
                grn_d[cur_way_d]  = 1'b1;
                walk_d[cur_way_d] = serviced_d && ((state_q != GREEN) || (t_value > WALK_MIN));
            end
            YELLOW: begin
                red_d[cur_way_d] = 1'b0;
                ylw_d[cur_way_d] = 1'b1;
            end
            FLASH: begin
                red_d = '0;
                ylw_d = flash_on_d ? '1 : '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ALL_RED;
            cur_way_q  <= '0;
            ped_pend_q <= '0;
            serviced_q <= 1'b0;
            flash_on_q <= 1'b0;
            fresh_q    <= 1'b1;
            red_q      <= '1;
            ylw_q      <= '0;
            grn_q      <= '0;
            walk_q     <= '0;
        end else begin
            state_q    <= state_d;
            cur_way_q  <= cur_way_d;
            ped_pend_q <= ped_pend_d;
            serviced_q <= serviced_d;
            flash_on_q <= flash_on_d;
            fresh_q    <= fresh_d;
            red_q      <= red_d;
            ylw_q      <= ylw_d;
            grn_q      <= grn_d;
            walk_q     <= walk_d;
        end
    end

    assign red  = red_q;
    assign ylw  = ylw_q;
    assign grn  = grn_q;
    assign walk = walk_q;

endmodule

// File: tb/tb_multi_way_intersection.sv
// Randomised self-checking bench for multi_way_intersection against a phase-schedule model.
module tb_multi_way_intersection;

    localparam int unsigned N    = 3;
    localparam int unsigned GRN  = 8;
    localparam int unsigned YLW  = 3;
    localparam int unsigned AR   = 2;
    localparam int unsigned WALK = 4;
    localparam int unsigned FLSH = 5;

    localparam int PH_AR = 0;
    localparam int PH_GR = 1;
    localparam int PH_YL = 2;
    localparam int PH_FL = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         flash_mode;
    logic [N-1:0] ped_req;
    logic [N-1:0] red, ylw, grn, walk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: which phase, how many cycles already spent in it, and whose turn it is.
    int           m_ph;
    int           m_t;
    int           m_way;
    bit           m_serv;
    bit           m_on;
    bit [N-1:0]   m_pend;

    always #5 clk = ~clk;

    multi_way_intersection #(
        .N_WAYS   (N),
        .GRN_CYC  (GRN),
        .YLW_CYC  (YLW),
        .AR_CYC   (AR),
        .WALK_CYC (WALK),
        .FLASH_CYC(FLSH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ped_req   (ped_req),
        .flash_mode(flash_mode),
        .red       (red),
        .ylw       (ylw),
        .grn       (grn),
        .walk      (walk)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    function automatic int dur(input int ph);
        case (ph)
            PH_GR:   return GRN;
            PH_YL:   return YLW;
            PH_FL:   return FLSH;
            default: return AR;
        endcase
    endfunction

    task automatic model_reset();
        m_ph   = PH_AR;
        m_t    = 0;
        m_way  = 0;
        m_serv = 0;
        m_on   = 0;
        m_pend = '0;
    endtask

    task automatic model_step();
        m_pend = m_pend | ped_req;
        m_t++;
        if (m_t >= dur(m_ph)) begin
            m_t = 0;
            case (m_ph)
                PH_AR: begin
                    if (flash_mode) begin
                        m_ph = PH_FL;
                        m_on = 1;
                    end else begin
                        m_ph          = PH_GR;
                        m_serv        = m_pend[m_way];
                        m_pend[m_way] = 1'b0;
                    end
                end
                PH_GR: m_ph = PH_YL;
                PH_YL: begin
                    m_ph  = PH_AR;
                    m_way = (m_way + 1) % N;
                end
                default: begin
                    if (m_on) m_on = 0;
                    else if (!flash_mode) m_ph = PH_AR;
                    else m_on = 1;
                end
            endcase
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] er, ey, eg, ew;
        int lit;
        bit one_lamp;
        er = '1; ey = '0; eg = '0; ew = '0;
        case (m_ph)
            PH_GR: begin
                er[m_way] = 1'b0;
                eg[m_way] = 1'b1;
                if (m_serv && m_t < WALK) ew[m_way] = 1'b1;
            end
            PH_YL: begin
                er[m_way] = 1'b0;
                ey[m_way] = 1'b1;
            end
            PH_FL: begin
                er = '0;
                ey = m_on ? '1 : '0;
            end
            default: ;
        endcase
        chk("red", 32'(red), 32'(er));
        chk("ylw", 32'(ylw), 32'(ey));
        chk("grn", 32'(grn), 32'(eg));
        chk("walk", 32'(walk), 32'(ew));
        if (m_ph != PH_FL) begin
            one_lamp = 1;
            for (int k = 0; k < N; k++) begin
                lit = int'(red[k]) + int'(ylw[k]) + int'(grn[k]);
                if (lit != 1) one_lamp = 0;
            end
            chk("one_lamp_per_way", 32'(one_lamp), 32'd1);
            chk("one_way_non_red", 32'($countones(~red) <= 1), 32'd1);
        end
    endtask

    // Advance n clocks: model steps on the rising edge, outputs checked and inputs driven on the falling edge.
    task automatic run_cycles(input int n, input int req_pct);
        repeat (n) begin
            @(posedge clk);
            if (!reset) model_step();
            @(negedge clk);
            check_outputs();
            for (int k = 0; k < N; k++) ped_req[k] = ($urandom_range(0, 99) < req_pct);
        end
    endtask

    task automatic pulse_req(input int k);
        ped_req    = '0;
        ped_req[k] = 1'b1;
        run_cycles(1, 0);
    endtask

    task automatic wait_grn(input int k, input int budget);
        int i = 0;
        while (grn[k] !== 1'b1 && i < budget) begin
            run_cycles(1, 0);
            i++;
        end
        chk("wait_grn", 32'(grn[k]), 32'd1);
    endtask

    task automatic wait_ylw(input int k, input int budget);
        int i = 0;
        while (ylw[k] !== 1'b1 && i < budget) begin
            run_cycles(1, 0);
            i++;
        end
        chk("wait_ylw", 32'(ylw[k]), 32'd1);
    endtask

    initial begin
        reset      = 1'b1;
        ped_req    = '0;
        flash_mode = 1'b0;
        model_reset();
        run_cycles(2, 0);
        reset = 1'b0;

        // Idle rotation, two full rounds.
        run_cycles(80, 0);

        // Walk request for way 2 raised during way 0's green.
        wait_grn(0, 60);
        pulse_req(2);
        run_cycles(80, 0);

        // Request for way 1 during its own green carries to the next round.
        wait_grn(1, 60);
        run_cycles(2, 0);
        pulse_req(1);
        run_cycles(80, 0);

        // Flash requested during way 1 green, later dropped.
        wait_grn(1, 60);
        flash_mode = 1'b1;
        run_cycles(40, 0);
        flash_mode = 1'b0;
        run_cycles(40, 0);

        // Asynchronous reset mid-yellow with a request pending.
        wait_ylw(0, 60);
        pulse_req(1);
        #2 reset = 1'b1;
        #1;
        chk("async_red", 32'(red), 32'({N{1'b1}}));
        chk("async_ylw", 32'(ylw), 32'd0);
        chk("async_grn", 32'(grn), 32'd0);
        chk("async_walk", 32'(walk), 32'd0);
        model_reset();
        run_cycles(1, 0);
        reset = 1'b0;
        run_cycles(60, 0);

        // Random requests and flash intervals.
        repeat (20) begin
            flash_mode = ($urandom_range(0, 5) == 0);
            run_cycles($urandom_range(10, 40), 10);
        end
        flash_mode = 1'b0;
        run_cycles(40, 10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multi_way_intersection.md
MULTI_WAY_INTERSECTION -- requirements
Module: multi_way_intersection

Interface
REQ-001 Parameter N_WAYS, default 2: number of approaches; legal range 2..8.
REQ-002 Parameter GRN_CYC, default 8: green phase length in clk cycles; must be >= 1.
REQ-003 Parameter YLW_CYC, default 3: yellow phase length in cycles; must be >= 1.
REQ-004 Parameter AR_CYC, default 2: all-red clearance length in cycles; must be >= 1.
REQ-005 Parameter WALK_CYC, default 4: walk-signal length in cycles; legal range 1..GRN_CYC.
REQ-006 Parameter FLASH_CYC, default 5: half-period of the flashing-yellow blink in cycles; must be >= 1.
REQ-007 Any illegal parameter value SHALL cause an elaboration-time error.
REQ-008 clk, input, 1: single clock; all state changes on its rising edge.
REQ-009 reset, input, 1: asynchronous, active-high reset.
REQ-010 ped_req, input, N_WAYS: pedestrian request per way; level-sampled each cycle.
REQ-011 flash_mode, input, 1: request for flashing-yellow maintenance mode.
REQ-012 red, output, N_WAYS: red lamp per way.
REQ-013 ylw, output, N_WAYS: yellow lamp per way.
REQ-014 grn, output, N_WAYS: green lamp per way.
REQ-015 walk, output, N_WAYS: pedestrian walk lamp per way.

Function
REQ-016 The FSM SHALL have four states: ALL_RED, GREEN, YELLOW and FLASH; all outputs are Moore outputs decoded from registered state.
REQ-017 ALL_RED: red is all ones, and ylw, grn and walk are zero; the state lasts exactly AR_CYC cycles.
REQ-018 At the end of ALL_RED, the FSM SHALL go to FLASH if flash_mode=1, otherwise to GREEN for way cur_way.
REQ-019 GREEN: grn[cur_way]=1 and red[cur_way]=0, and every other way shows red; the state lasts exactly GRN_CYC cycles and is followed by YELLOW.
REQ-020 YELLOW: ylw[cur_way]=1 and every other way shows red; the state lasts exactly YLW_CYC cycles and is followed by ALL_RED.
REQ-021 On leaving YELLOW, cur_way SHALL increment modulo N_WAYS, wrapping from N_WAYS-1 to 0.
REQ-022 Outside FLASH, each way SHALL have exactly one of red, ylw or grn asserted.
REQ-023 At most one way SHALL show non-red in any cycle.
REQ-024 ped_pend[k] SHALL be set on any cycle in which ped_req[k]=1.
REQ-025 ped_pend[k] SHALL be sampled and cleared on the cycle GREEN of way k is entered.
REQ-026 A request arriving on that same entry cycle is merged into the current service and is not carried forward.
REQ-027 walk[k] SHALL be 1 for the first WALK_CYC cycles of GREEN of way k if ped_pend[k] was set at entry, and 0 otherwise.
REQ-028 A request for way k during its own GREEN or YELLOW SHALL remain pending until that way's next GREEN.
REQ-029 flash_mode SHALL be ignored in GREEN and YELLOW, and is acted on only at the end of ALL_RED.
REQ-030 FLASH: red, grn and walk are zero, and ylw toggles between all ones and all zeros every FLASH_CYC cycles, starting with all ones.
REQ-031 In FLASH, ped_req SHALL still set ped_pend.
REQ-032 FLASH SHALL exit only at the end of an off half-period with flash_mode=0, and then goes to ALL_RED.
REQ-033 cur_way SHALL be unchanged across FLASH, so service resumes at the way that would have been next.
REQ-034 The phase counter width SHALL be $clog2 of max(GRN_CYC, YLW_CYC, AR_CYC, FLASH_CYC)+1, and the counter SHALL never wrap.

Reset
REQ-035 While reset=1, the block SHALL be in state ALL_RED with cur_way=0, phase counter=0, ped_pend=0, red all ones, and ylw, grn and walk all zero.
REQ-036 Reset asserted mid-phase SHALL force the reset values immediately, without waiting for a clock edge.
REQ-037 After reset deassertion, the block SHALL run a full AR_CYC clearance before the first green, which is grn[0].

Structure
REQ-038 Package traffic_pkg SHALL hold the state enum (ALL_RED, GREEN, YELLOW, FLASH) and the default timing constants.
REQ-039 Sub-module phase_timer SHALL be a loadable down-counter with load, value and done outputs, instantiated once.
REQ-040 The FSM, way pointer, ped_pend register and output decode SHALL reside in multi_way_intersection.

Verification
Scenarios use N_WAYS=3, GRN=8, YLW=3, AR=2, WALK=4 and FLASH=5.
REQ-041 Release reset, no requests -> red for 2 cycles, grn[0] for 8, ylw[0] for 3, red for 2, then grn[1]; the sequence wraps back to grn[0] after way 2.
REQ-042 Pulse ped_req[2] for 1 cycle during grn[0] -> walk[2]=1 for the first 4 cycles of grn[2] only; walk stays 0 in the following round.
REQ-043 Pulse ped_req[1] during grn[1] -> no walk in that green; walk[1] asserts in way 1's next green.
REQ-044 Raise flash_mode during grn[1] -> yellow and all-red complete, then ylw=111 for 5 cycles and 000 for 5 cycles, repeating. Drop flash_mode -> exit at the next off boundary, 2 cycles all-red, then grn[2].
REQ-045 Assert reset for a partial cycle mid-YELLOW -> outputs go to all-red asynchronously, and the sequence restarts at way 0 with ped_pend cleared.
REQ-046 Every scenario SHALL continuously check that each way has exactly one lamp lit outside FLASH and that at most one way is non-red.
